// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: default widths,
// memory depth, reset vector and FSM state encoding.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF     = 16;
    localparam int unsigned INSTR_W_DEF    = 16;
    localparam int unsigned IMEM_DEPTH_DEF = 256;
    localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_perf_counter.sv
// Fetch performance counters: delivered instructions and decode-stall cycles.
module fetch_perf_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        ready,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    // Count transfers and stalled presentation cycles; both wrap at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (valid && ready)  fetch_cnt <= fetch_cnt + 32'd1;
            if (valid && !ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: owns the PC, sequences a 1-cycle synchronous
// instruction memory and presents instructions to decode via valid/ready.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetch_cnt/perf_stall_cnt.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W       = ADDR_W_DEF,
    parameter int unsigned       INSTR_W      = INSTR_W_DEF,
    parameter int unsigned       IMEM_DEPTH   = IMEM_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst,
    output logic [ADDR_W-1:0]  inst_pc,
    output logic               inst_fault,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    input  logic               resume_req,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic              stall;
    logic              issue;

    assign stall      = rsp_valid_q && !inst_ready;
    assign inst_valid = rsp_valid_q;
    assign inst_pc    = rsp_pc_q;
    assign inst_fault = rsp_fault_q;
    assign inst       = imem_data;
    assign halted     = (state_q == ST_HALTED);

    // A stalled instruction must be re-read so imem_data stays on it; this
    // also covers a halt raised during a stall, whose DRAIN cycles replay it.
    assign imem_addr = stall ? rsp_pc_q : pc_q;

    // State, PC and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_VECTOR;
            rsp_valid_q <= 1'b0;
            rsp_pc_q    <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    // Next-state: redirect beats halt beats stall; issue advances the PC.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_fault_d = rsp_fault_q;
        issue       = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_d        = redirect_pc;
                    rsp_valid_d = 1'b0;
                    if (halt_req) state_d = ST_HALTED;
                end else if (halt_req) begin
                    if (stall) begin
                        state_d = ST_DRAIN;
                    end else begin
                        rsp_valid_d = 1'b0;
                        state_d     = ST_HALTED;
                    end
                end else if (!stall) begin
                    issue = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    pc_d        = redirect_pc;
                    rsp_valid_d = 1'b0;
                    state_d     = ST_HALTED;
                end else if (inst_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (resume_req && !halt_req) begin
                    state_d = ST_FETCH;
                    issue   = !redirect_valid;
                end
            end
            default: begin
                state_d     = ST_FETCH;
                rsp_valid_d = 1'b0;
            end
        endcase

        if (issue) begin
            pc_d        = pc_q + ADDR_W'(1);
            rsp_valid_d = 1'b1;
            rsp_pc_d    = pc_q;
            rsp_fault_d = ((ADDR_W+1)'(pc_q) >= (ADDR_W+1)'(IMEM_DEPTH));
        end
    end

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counter u_perf (
        .clk       (clk),
        .reset     (reset),
        .valid     (rsp_valid_q),
        .ready     (inst_ready),
        .fetch_cnt (perf_fetch_cnt),
        .stall_cnt (perf_stall_cnt)
    );
`endif

endmodule
